ccol_to_c_sram: RTL and testbench
=================================

CCOL_TO_C_SRAM -- requirements
Module: ccol_to_c_sram

Interface
REQ-001 SHALL have parameter M, default 8, number of output-column elements (SRAM rows).
REQ-002 SHALL have parameter KMAX, default 1024, SRAM column depth.
REQ-003 SHALL have parameter DATA_W, default 32, element width.
REQ-004 SHALL have parameter BYTE_W, default DATA_W/8, write-mask width; derived ROW_W = clog2(M) (min 1), K_W = clog2(KMAX) (min 1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ccol_valid  input  1  column vector offered.
REQ-008 SHALL have port ccol_ready  output  1  block can accept a column.
REQ-009 SHALL have port k_idx  input  K_W  destination column index, sampled on accept.
REQ-010 SHALL have port c_col  input  M x DATA_W  column elements, element r goes to row r.
REQ-011 SHALL have port row_en  input  M  per-row write enable, sampled on accept.
REQ-012 SHALL have ports c_en, c_re, c_we  output  1 each  SRAM strobes.
REQ-013 SHALL have ports c_row  output  ROW_W, c_k  output  K_W, c_wdata  output  DATA_W, c_wmask  output  BYTE_W  SRAM address/data/mask.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port wr_done  output  1  one-cycle pulse after the last write of a column.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 SHALL drive ccol_ready=1 only in IDLE; a transfer occurs on a rising edge with ccol_valid && ccol_ready.
REQ-018 SHALL on transfer register c_col, k_idx and row_en; later input changes SHALL not affect the column in flight.
REQ-019 SHALL on transfer go to WRITE if registered row_en != 0, else go directly to DONE (no SRAM access).
REQ-020 SHALL in WRITE issue exactly one write per cycle to the lowest-indexed remaining enabled row: c_en=1, c_we=1, c_re=0, c_row=r, c_k=latched k, c_wdata=latched element r, c_wmask=all ones.
REQ-021 SHALL skip disabled rows without spending a cycle; n enabled rows take exactly n WRITE cycles.
REQ-022 SHALL clear each row's pending bit as it is written and move WRITE -> DONE in the cycle after the last enabled row is written.
REQ-023 SHALL in DONE assert wr_done=1 for exactly one cycle, then return to IDLE.
REQ-024 Timing: transfer at edge t -> writes on cycles t+1..t+n, wr_done on cycle t+n+1, ccol_ready=1 again on cycle t+n+2.
REQ-025 SHALL drive c_en=c_we=0, c_wmask=0, c_row=0, c_k=0, c_wdata=0 in IDLE and DONE; c_re SHALL be 0 at all times.
REQ-026 SHALL ignore ccol_valid while busy; no second column is captured and no in-flight data is altered.
REQ-027 SHALL assume SRAM accepts one write per cycle with no backpressure; no read-return inputs exist.
REQ-028 SHALL write k_idx unchanged to c_k for every row of the column, including k_idx = KMAX-1.

Reset
REQ-029 SHALL on rst asserted, asynchronously and without waiting for clk, force state IDLE, clear pending row bits and latched data, and drive c_en=c_we=c_re=0, c_wmask=0, busy=0, wr_done=0.
REQ-030 SHALL hold ccol_ready=0 while rst is asserted and ignore ccol_valid.
REQ-031 SHALL on rst mid-WRITE abort the column: no further writes, no wr_done pulse.
REQ-032 SHALL after rst deassertion present ccol_ready=1 on the first cycle.

Verification
REQ-033 Full column: k_idx=0, c_col[r]=0xA000_0000+(r<<16), row_en=0xFF -> 8 consecutive writes rows 0..7, c_k=0, matching data, wmask=0xF, wr_done on the 9th cycle after accept.
REQ-034 Sparse mask: k_idx=7, row_en=0b1000_0101 -> exactly 3 writes on consecutive cycles to rows 0,2,7 with c_k=7, then wr_done.
REQ-035 Empty mask: row_en=0 -> no c_en cycle, wr_done on cycle t+1, ccol_ready back on t+2.
REQ-036 Busy rejection: accept k=3, then ccol_valid with k=9 and new data during WRITE -> only k=3 data written, k=9 accepted only after return to IDLE.
REQ-037 Boundary: k_idx=1023 with changing c_col inputs after accept -> all writes use c_k=1023 and the latched data.
REQ-038 Reset mid-op: assert rst after 3 writes of a full column -> outputs zero immediately (before next clk edge), no more writes, no wr_done, ccol_ready=1 first cycle after release.

Source files
------------

// File: rtl/ccol_to_c_sram.sv
// ---------------------------------------------------------------------------
// ccol_to_c_sram
//
// Takes one M-element column vector per transfer and scatters it into a
// row-organised SRAM: element r of the column lands in SRAM row r at column
// k_idx. Only rows whose row_en bit is set are written. Writes go out at one
// per cycle, with disabled rows skipped for free. A one-cycle wr_done pulse
// follows the last write.
//
// Handshake: ccol_valid/ccol_ready use strict valid/ready semantics. A
// transfer happens on a rising clk edge where both are high. ccol_ready is
// high only in IDLE and never while rst is asserted. The producer may change
// or drop its inputs freely once the transfer edge has passed.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   ccol_valid/ready  column offer / block can accept
//   k_idx             destination SRAM column (sampled on accept)
//   c_col             M x DATA_W packed column, element r at [r*DATA_W +: DATA_W]
//   row_en            per-row write enable (sampled on accept)
//   c_en/c_re/c_we    SRAM strobes (c_re is never asserted)
//   c_row/c_k         SRAM row / column address
//   c_wdata/c_wmask   SRAM write data / byte mask
//   busy              high whenever the FSM is outside IDLE
//   wr_done           one-cycle pulse after the last write of a column
//   dbg_state         current FSM state, for observation
// ---------------------------------------------------------------------------
module ccol_to_c_sram #(
  parameter int M      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  localparam int ROW_W = (M > 1) ? $clog2(M) : 1,
  localparam int K_W   = (KMAX > 1) ? $clog2(KMAX) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ccol_valid,
  output logic                  ccol_ready,
  input  logic [K_W-1:0]        k_idx,
  input  logic [M*DATA_W-1:0]   c_col,
  input  logic [M-1:0]          row_en,
  output logic                  c_en,
  output logic                  c_re,
  output logic                  c_we,
  output logic [ROW_W-1:0]      c_row,
  output logic [K_W-1:0]        c_k,
  output logic [DATA_W-1:0]     c_wdata,
  output logic [BYTE_W-1:0]     c_wmask,
  output logic                  busy,
  output logic                  wr_done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [M-1:0]          pend_q;     // rows still to be written
  logic [M*DATA_W-1:0]   data_q;     // latched column
  logic [K_W-1:0]        k_q;        // latched destination column

  logic                  c_en_q;
  logic                  c_we_q;
  logic [ROW_W-1:0]      c_row_q;
  logic [K_W-1:0]        c_k_q;
  logic [DATA_W-1:0]     c_wdata_q;
  logic [BYTE_W-1:0]     c_wmask_q;
  logic                  wr_done_q;

  // Index of the lowest set bit; 0 when no bit is set (callers guard that).
  function automatic logic [ROW_W-1:0] lowest_row(input logic [M-1:0] v);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (v[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  logic [ROW_W-1:0] acc_row;    // first row to write straight off the accept
  logic [M-1:0]     acc_rest;   // row_en with its lowest bit cleared
  logic [ROW_W-1:0] pend_row;   // next row to write while in WRITE
  logic [M-1:0]     pend_rest;  // pend_q with its lowest bit cleared

  always_comb begin
    acc_row   = lowest_row(row_en);
    pend_row  = lowest_row(pend_q);
    // v & (v - 1) clears exactly the lowest set bit.
    acc_rest  = row_en & (row_en - 1'b1);
    pend_rest = pend_q & (pend_q - 1'b1);
  end

  // The first write is set up on the accept edge itself, so it appears in
  // the very next cycle. Each write is registered one cycle ahead from the
  // pending mask. When the mask is empty, the FSM enters DONE and raises
  // wr_done for exactly that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      data_q    <= '0;
      k_q       <= '0;
      c_en_q    <= 1'b0;
      c_we_q    <= 1'b0;
      c_row_q   <= '0;
      c_k_q     <= '0;
      c_wdata_q <= '0;
      c_wmask_q <= '0;
      wr_done_q <= 1'b0;
    end else begin
      // Strobes and address/data default to idle values every cycle.
      c_en_q    <= 1'b0;
      c_we_q    <= 1'b0;
      c_row_q   <= '0;
      c_k_q     <= '0;
      c_wdata_q <= '0;
      c_wmask_q <= '0;
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ccol_valid) begin
            data_q <= c_col;
            k_q    <= k_idx;
            if (row_en != '0) begin
              state_q   <= WRITE;
              pend_q    <= acc_rest;
              c_en_q    <= 1'b1;
              c_we_q    <= 1'b1;
              c_row_q   <= acc_row;
              c_k_q     <= k_idx;
              c_wdata_q <= c_col[acc_row*DATA_W +: DATA_W];
              c_wmask_q <= '1;
            end else begin
              state_q   <= DONE;
              pend_q    <= '0;
              wr_done_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (pend_q != '0) begin
            pend_q    <= pend_rest;
            c_en_q    <= 1'b1;
            c_we_q    <= 1'b1;
            c_row_q   <= pend_row;
            c_k_q     <= k_q;
            c_wdata_q <= data_q[pend_row*DATA_W +: DATA_W];
            c_wmask_q <= '1;
          end else begin
            // The last write is on the bus this cycle; the pulse follows it.
            state_q   <= DONE;
            wr_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          pend_q  <= '0;
        end
      endcase
    end
  end

  // ccol_ready is gated by rst so that it stays low while reset is held,
  // yet rises in the first cycle after release.
  assign ccol_ready = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign c_en       = c_en_q;
  assign c_we       = c_we_q;
  assign c_re       = 1'b0;
  assign c_row      = c_row_q;
  assign c_k        = c_k_q;
  assign c_wdata    = c_wdata_q;
  assign c_wmask    = c_wmask_q;
  assign wr_done    = wr_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ccol_to_c_sram.sv
// ---------------------------------------------------------------------------
// Bench for ccol_to_c_sram. Directed columns are driven at negedges. Each
// expected SRAM write and wr_done pulse is pushed into exp_q at issue time.
// A negedge monitor pops and compares whenever the DUT shows any activity
// on its SRAM or done outputs.
// ---------------------------------------------------------------------------
module tb_ccol_to_c_sram;
  localparam int M      = 8;
  localparam int KMAX   = 1024;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 4;
  localparam int ROW_W  = 3;
  localparam int K_W    = 10;
  // {wr_done, c_en, c_we, c_re, c_wmask, c_row, c_k, c_wdata}
  localparam int W = 4 + BYTE_W + ROW_W + K_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                ccol_valid;
  logic                ccol_ready;
  logic [K_W-1:0]      k_idx;
  logic [M*DATA_W-1:0] c_col;
  logic [M-1:0]        row_en;
  logic                c_en, c_re, c_we;
  logic [ROW_W-1:0]    c_row;
  logic [K_W-1:0]      c_k;
  logic [DATA_W-1:0]   c_wdata;
  logic [BYTE_W-1:0]   c_wmask;
  logic                busy, wr_done;
  logic [1:0]          dbg_state;

  ccol_to_c_sram #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .rst(rst),
    .ccol_valid(ccol_valid), .ccol_ready(ccol_ready),
    .k_idx(k_idx), .c_col(c_col), .row_en(row_en),
    .c_en(c_en), .c_re(c_re), .c_we(c_we),
    .c_row(c_row), .c_k(c_k), .c_wdata(c_wdata), .c_wmask(c_wmask),
    .busy(busy), .wr_done(wr_done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] col_d [M];
  logic [W-1:0]      mon_got;
  logic [W-1:0]      mon_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wr_item(input int r, input logic [K_W-1:0] k,
                                           input logic [DATA_W-1:0] d);
    return {1'b0, 1'b1, 1'b1, 1'b0, {BYTE_W{1'b1}}, ROW_W'(r), k, d};
  endfunction

  function automatic logic [W-1:0] done_item();
    return {1'b1, {(W-1){1'b0}}};
  endfunction

  // Monitor: any non-idle output must match the head of the expected queue.
  always @(negedge clk) begin
    mon_got = {wr_done, c_en, c_we, c_re, c_wmask, c_row, c_k, c_wdata};
    if (mon_got != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(mon_got), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sram_out", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive a column from col_d and queue its expected writes, in row order.
  // max_wr limits how many writes are queued; with_done queues the pulse.
  task automatic apply(input logic [K_W-1:0] k, input logic [M-1:0] en,
                       input int max_wr, input bit with_done);
    int nq = 0;
    for (int r = 0; r < M; r++) c_col[r*DATA_W +: DATA_W] = col_d[r];
    k_idx      = k;
    row_en     = en;
    ccol_valid = 1'b1;
    for (int r = 0; r < M; r++) begin
      if (en[r] && nq < max_wr) begin
        exp_q.push_back(wr_item(r, k, col_d[r]));
        nq++;
      end
    end
    if (with_done) exp_q.push_back(done_item());
  endtask

  // Wait (bounded) for ready, then pass the transfer edge; return at edge+1.
  task automatic accept();
    int n = 0;
    while (!ccol_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Timing after a transfer: n writes, wr_done at cycle n+1, ready at n+2.
  task automatic wait_col(input int n, input string tag);
    int cyc = 0, dcyc = 0, wr = 0;
    while (cyc < 40 && dcyc == 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (wr_done) dcyc = cyc;
      else if (c_en) wr++;
    end
    check({tag, "_done_lat"}, 64'(dcyc), 64'(n + 1));
    check({tag, "_nwrites"}, 64'(wr), 64'(n));
    @(negedge clk);
    check({tag, "_ready"}, 64'(ccol_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ccol_valid = 1'b0;
    k_idx = '0;
    c_col = '0;
    row_en = '0;

    // Reset state
    #1;
    check("rst_ready", 64'(ccol_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", 64'({wr_done, c_en, c_we, c_re, c_wmask}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ccol_ready), 64'd1);
    @(negedge clk);

    // Full column
    for (int r = 0; r < M; r++) col_d[r] = 32'hA000_0000 + (r << 16);
    apply(10'd0, 8'hFF, M, 1'b1);
    accept();
    ccol_valid = 1'b0;
    wait_col(8, "full");

    // Sparse mask: rows 0, 2, 7
    for (int r = 0; r < M; r++) col_d[r] = 32'h5000_0000 + r * 32'h0101;
    apply(10'd7, 8'b1000_0101, M, 1'b1);
    accept();
    ccol_valid = 1'b0;
    wait_col(3, "sparse");

    // Empty mask: no SRAM access, just the pulse
    apply(10'd2, 8'h00, M, 1'b1);
    accept();
    ccol_valid = 1'b0;
    wait_col(0, "empty");

    // Busy rejection: k=9 offered during WRITE of k=3, taken only afterwards
    for (int r = 0; r < M; r++) col_d[r] = 32'h3333_0000 + r;
    apply(10'd3, 8'h0F, M, 1'b1);
    accept();
    for (int r = 0; r < M; r++) col_d[r] = 32'h9999_0000 + r;
    apply(10'd9, 8'hF0, M, 1'b1);
    #1;
    check("busy_ready_low", 64'(ccol_ready), 64'd0);
    wait_col(4, "busy_k3");
    @(posedge clk);
    #1;
    ccol_valid = 1'b0;
    wait_col(4, "busy_k9");

    // Boundary k=1023, inputs scrambled after accept
    for (int r = 0; r < M; r++) col_d[r] = 32'hBEEF_0000 + (r << 4);
    apply(10'd1023, 8'hFF, M, 1'b1);
    accept();
    ccol_valid = 1'b0;
    for (int r = 0; r < M; r++) c_col[r*DATA_W +: DATA_W] = $urandom();
    k_idx  = 10'($urandom_range(0, 1022));
    row_en = 8'h00;
    wait_col(8, "kmax");

    // Reset mid-WRITE after 3 writes
    for (int r = 0; r < M; r++) col_d[r] = 32'hC0DE_0000 + r;
    apply(10'd5, 8'hFF, 3, 1'b0);
    accept();
    ccol_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_outs", 64'({wr_done, c_en, c_we, c_re, c_wmask, c_row, c_k, c_wdata}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ccol_ready), 64'd0);
    ccol_valid = 1'b1;
    k_idx = 10'd11;
    repeat (2) @(negedge clk);
    check("midrst_hold_ready", 64'(ccol_ready), 64'd0);
    check("midrst_hold_state", 64'(dbg_state), 64'd0);
    ccol_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 64'(ccol_ready), 64'd1);
    repeat (12) @(negedge clk);
    check("midrst_idle", 64'(busy), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
